// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue
//
// Instruction issue queue sitting between fetch and the dual-issue
// dependency checker. Fetch pushes one or two instructions per cycle
// (pc, instruction word, predictor state). The checker sees the two oldest
// entries and reports how many it consumed each cycle (pop_cnt). A
// mispredict flush discards everything that is queued.
//
// Storage is a circular buffer of DEPTH entries (DEPTH a power of two, >= 4)
// with a write pointer, a read pointer and an occupancy count. Pointers wrap
// naturally modulo DEPTH.
//
// Optional feature (macro ISSUE_QUEUE_BYPASS_EN):
//   When defined, the visible head slots are the first two entries of
//   {stored entries, incoming accepted push}. Incoming instructions can be
//   seen and popped in the same cycle they are pushed. Popped incoming
//   entries are never written to storage. When the macro is undefined,
//   a pushed instruction becomes visible one cycle after the push.
//
// Ports:
//   CLK                       clock
//   NRST                      synchronous active-low reset (pointers/count)
//   push_valid                fetch presents a pair this cycle
//   push_second               slot 2 of the pair is valid
//   push_pc1/2                pcs of the pair
//   push_inst1/2              instruction words of the pair
//   push_state1/2             predictor states of the pair
//   push_ready                queue can accept a pair (from registered count)
//   pop_cnt                   entries consumed this cycle (3 is treated as 2)
//   flush                     mispredict: discard all entries
//   out_valid1/2              head / head+1 valid
//   out_pc1/2                 head pcs (zero when invalid)
//   out_inst1/2               head instructions (zero when invalid)
//   out_state1/2              head predictor states (zero when invalid)
//   count                     number of occupied entries
// ---------------------------------------------------------------------------
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int PCW   = 13
) (
    input  logic                     CLK,
    input  logic                     NRST,
    input  logic                     push_valid,
    input  logic                     push_second,
    input  logic [PCW-1:0]           push_pc1,
    input  logic [PCW-1:0]           push_pc2,
    input  logic [31:0]              push_inst1,
    input  logic [31:0]              push_inst2,
    input  logic [1:0]               push_state1,
    input  logic [1:0]               push_state2,
    output logic                     push_ready,
    input  logic [1:0]               pop_cnt,
    input  logic                     flush,
    output logic                     out_valid1,
    output logic                     out_valid2,
    output logic [PCW-1:0]           out_pc1,
    output logic [PCW-1:0]           out_pc2,
    output logic [31:0]              out_inst1,
    output logic [31:0]              out_inst2,
    output logic [1:0]               out_state1,
    output logic [1:0]               out_state2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ------------------------------------------------------------------
    // Storage (not reset: only pointers and count are cleared)
    // ------------------------------------------------------------------
    logic [PCW-1:0] pc_mem   [DEPTH];
    logic [31:0]    inst_mem [DEPTH];
    logic [1:0]     st_mem   [DEPTH];

    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW-1:0]  wptr_p1;
    logic [AW-1:0]  rptr_p1;

    // ------------------------------------------------------------------
    // Push / pop bookkeeping
    // ------------------------------------------------------------------
    logic           accept;       // push taken this cycle
    logic [1:0]     push_n;       // entries in the accepted push (0..2)
    logic [1:0]     in_n;         // incoming entries visible this cycle
    logic [1:0]     pop_req;      // pop_cnt with 3 clamped to 2
    logic [1:0]     stored_vis;   // stored entries visible at the head (0..2)
    logic [2:0]     avail;        // entries that can be popped this cycle
    logic [1:0]     pop_eff;      // effective pop
    logic [1:0]     pop_stored;   // part of the pop taken from storage
    logic [1:0]     pop_in;       // part of the pop taken from the incoming push

    // Storage write ports for this cycle
    logic           wr0_en;
    logic           wr1_en;
    logic [PCW-1:0] wr0_pc;
    logic [31:0]    wr0_inst;
    logic [1:0]     wr0_st;

    logic [CW-1:0]  count_next;
    logic [AW-1:0]  wptr_next;
    logic [AW-1:0]  rptr_next;

    assign wptr_p1 = wptr + AW'(1);
    assign rptr_p1 = rptr + AW'(1);

    // Full boundary is taken from the registered count only, so a pop in the
    // same cycle never makes room for a push.
    assign push_ready = (count <= CW'(DEPTH - 2));
    assign accept     = push_valid & push_ready;

    always_comb begin
        push_n = 2'd0;
        if (accept) begin
            push_n = push_second ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        pop_req = pop_cnt[1] ? 2'd2 : {1'b0, pop_cnt[0]};
    end

    always_comb begin
        stored_vis = (count >= CW'(2)) ? 2'd2 : count[1:0];
    end

`ifdef ISSUE_QUEUE_BYPASS_EN
    // A flushed push is never visible, stored or popped.
    assign in_n = flush ? 2'd0 : push_n;
`else
    assign in_n = 2'd0;
`endif

    always_comb begin
        avail = {1'b0, stored_vis} + {1'b0, in_n};
        if (avail > 3'd2) begin
            avail = 3'd2;
        end
    end

    always_comb begin
        pop_eff = ({1'b0, pop_req} < avail) ? pop_req : avail[1:0];
    end

    // Storage is always consumed first; the incoming push is only popped once
    // every stored entry has gone.
    always_comb begin
        pop_stored = (pop_eff < stored_vis) ? pop_eff : stored_vis;
        pop_in     = pop_eff - pop_stored;
    end

    // ------------------------------------------------------------------
    // Write selection: the un-popped tail of the incoming push lands at
    // wptr, wptr+1.
    // ------------------------------------------------------------------
    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_pc   = push_pc1;
        wr0_inst = push_inst1;
        wr0_st   = push_state1;
        if (NRST && !flush && accept) begin
            if (pop_in == 2'd0) begin
                wr0_en = 1'b1;
                wr1_en = push_second;
            end else if (pop_in == 2'd1 && push_second) begin
                // First instruction consumed by the bypass; second goes to wptr.
                wr0_en   = 1'b1;
                wr0_pc   = push_pc2;
                wr0_inst = push_inst2;
                wr0_st   = push_state2;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr0_en) begin
            pc_mem[wptr]   <= wr0_pc;
            inst_mem[wptr] <= wr0_inst;
            st_mem[wptr]   <= wr0_st;
        end
        if (wr1_en) begin
            pc_mem[wptr_p1]   <= push_pc2;
            inst_mem[wptr_p1] <= push_inst2;
            st_mem[wptr_p1]   <= push_state2;
        end
    end

    // ------------------------------------------------------------------
    // Pointer / count update
    // ------------------------------------------------------------------
    always_comb begin
        count_next = count + CW'(push_n) - CW'(pop_eff);
        wptr_next  = wptr + AW'(push_n - pop_in);
        rptr_next  = rptr + AW'(pop_stored);
    end

    always_ff @(posedge CLK) begin
        if (!NRST || flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            count <= count_next;
            wptr  <= wptr_next;
            rptr  <= rptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Head outputs: combinational reads, zero when not backed by an entry
    // ------------------------------------------------------------------
    always_comb begin
        out_valid1 = 1'b0;
        out_pc1    = '0;
        out_inst1  = '0;
        out_state1 = '0;
        out_valid2 = 1'b0;
        out_pc2    = '0;
        out_inst2  = '0;
        out_state2 = '0;

        if (stored_vis != 2'd0) begin
            out_valid1 = 1'b1;
            out_pc1    = pc_mem[rptr];
            out_inst1  = inst_mem[rptr];
            out_state1 = st_mem[rptr];
        end else if (in_n != 2'd0) begin
            out_valid1 = 1'b1;
            out_pc1    = push_pc1;
            out_inst1  = push_inst1;
            out_state1 = push_state1;
        end

        if (stored_vis == 2'd2) begin
            out_valid2 = 1'b1;
            out_pc2    = pc_mem[rptr_p1];
            out_inst2  = inst_mem[rptr_p1];
            out_state2 = st_mem[rptr_p1];
        end else if (stored_vis == 2'd1 && in_n != 2'd0) begin
            out_valid2 = 1'b1;
            out_pc2    = push_pc1;
            out_inst2  = push_inst1;
            out_state2 = push_state1;
        end else if (stored_vis == 2'd0 && in_n == 2'd2) begin
            out_valid2 = 1'b1;
            out_pc2    = push_pc2;
            out_inst2  = push_inst2;
            out_state2 = push_state2;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_issue_queue
//
// Self-checking bench for issue_queue. A behavioural model keeps the queue
// contents as a plain SystemVerilog queue of entries; every step compares all
// DUT outputs with the model. Directed steps follow the test plan, then a
// randomized phase exercises push/pop/flush/reset mixes.
// ---------------------------------------------------------------------------
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int PCW   = 13;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [31:0]    inst;
        logic [1:0]     st;
    } entry_t;

    logic           CLK;
    logic           NRST;
    logic           push_valid;
    logic           push_second;
    logic [PCW-1:0] push_pc1;
    logic [PCW-1:0] push_pc2;
    logic [31:0]    push_inst1;
    logic [31:0]    push_inst2;
    logic [1:0]     push_state1;
    logic [1:0]     push_state2;
    logic           push_ready;
    logic [1:0]     pop_cnt;
    logic           flush;
    logic           out_valid1;
    logic           out_valid2;
    logic [PCW-1:0] out_pc1;
    logic [PCW-1:0] out_pc2;
    logic [31:0]    out_inst1;
    logic [31:0]    out_inst2;
    logic [1:0]     out_state1;
    logic [1:0]     out_state2;
    logic [CW-1:0]  count;

    int checks   = 0;
    int failures = 0;

    entry_t model_q[$];

    issue_queue #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .CLK(CLK),
        .NRST(NRST),
        .push_valid(push_valid),
        .push_second(push_second),
        .push_pc1(push_pc1),
        .push_pc2(push_pc2),
        .push_inst1(push_inst1),
        .push_inst2(push_inst2),
        .push_state1(push_state1),
        .push_state2(push_state2),
        .push_ready(push_ready),
        .pop_cnt(pop_cnt),
        .flush(flush),
        .out_valid1(out_valid1),
        .out_valid2(out_valid2),
        .out_pc1(out_pc1),
        .out_pc2(out_pc2),
        .out_inst1(out_inst1),
        .out_inst2(out_inst2),
        .out_state1(out_state1),
        .out_state2(out_state2),
        .count(count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step: drive inputs, compare outputs against the model away
    // from the edge, advance the model, then cross the rising edge.
    task automatic step(input logic pv, input logic ps,
                        input logic [PCW-1:0] pc1, input logic [PCW-1:0] pc2,
                        input logic [1:0] popc, input logic fl, input logic rn);
        entry_t e1, e2;
        entry_t inc[$];
        entry_t vis[$];
        entry_t nxt[$];
        int     req;
        int     np;
        logic   exp_ready;

        e1.pc = pc1; e1.inst = $urandom; e1.st = 2'($urandom);
        e2.pc = pc2; e2.inst = $urandom; e2.st = 2'($urandom);

        push_valid  = pv;
        push_second = ps;
        push_pc1    = e1.pc;
        push_pc2    = e2.pc;
        push_inst1  = e1.inst;
        push_inst2  = e2.inst;
        push_state1 = e1.st;
        push_state2 = e2.st;
        pop_cnt     = popc;
        flush       = fl;
        NRST        = rn;
        #3;

        exp_ready = (model_q.size() <= DEPTH - 2);
        if (pv && exp_ready) begin
            inc.push_back(e1);
            if (ps) inc.push_back(e2);
        end
        vis = model_q;
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (!fl) begin
            foreach (inc[i]) vis.push_back(inc[i]);
        end
`endif

        chk("count", 64'(count), 64'(model_q.size()));
        chk("push_ready", 64'(push_ready), 64'(exp_ready));
        chk("out_valid1", 64'(out_valid1), 64'(vis.size() >= 1));
        chk("out_valid2", 64'(out_valid2), 64'(vis.size() >= 2));
        chk("out_pc1",    64'(out_pc1),    (vis.size() >= 1) ? 64'(vis[0].pc)   : 64'd0);
        chk("out_pc2",    64'(out_pc2),    (vis.size() >= 2) ? 64'(vis[1].pc)   : 64'd0);
        chk("out_inst1",  64'(out_inst1),  (vis.size() >= 1) ? 64'(vis[0].inst) : 64'd0);
        chk("out_inst2",  64'(out_inst2),  (vis.size() >= 2) ? 64'(vis[1].inst) : 64'd0);
        chk("out_state1", 64'(out_state1), (vis.size() >= 1) ? 64'(vis[0].st)   : 64'd0);
        chk("out_state2", 64'(out_state2), (vis.size() >= 2) ? 64'(vis[1].st)   : 64'd0);

        if (!rn || fl) begin
            model_q.delete();
        end else begin
            req = (popc == 2'd3) ? 2 : int'(popc);
            np  = (req < vis.size()) ? req : vis.size();
            nxt = model_q;
            foreach (inc[i]) nxt.push_back(inc[i]);
            repeat (np) void'(nxt.pop_front());
            model_q = nxt;
        end

        @(posedge CLK);
        #1;
    endtask

    initial begin
        NRST        = 1'b0;
        push_valid  = 1'b0;
        push_second = 1'b0;
        push_pc1    = '0;
        push_pc2    = '0;
        push_inst1  = '0;
        push_inst2  = '0;
        push_state1 = '0;
        push_state2 = '0;
        pop_cnt     = 2'd0;
        flush       = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        NRST = 1'b1;
        #3;

        // Reset / idle state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_push_ready", 64'(push_ready), 64'd1);
        chk("rst_valid1", 64'(out_valid1), 64'd0);
        chk("rst_valid2", 64'(out_valid2), 64'd0);
        chk("rst_inst1", 64'(out_inst1), 64'd0);
        chk("rst_inst2", 64'(out_inst2), 64'd0);
        @(posedge CLK);
        #1;
        model_q.delete();

        // Single pair then drain one at a time
        step(1, 1, 13'h10, 13'h14, 2'd0, 0, 1);
        step(0, 0, 13'h0,  13'h0,  2'd1, 0, 1);
        step(0, 0, 13'h0,  13'h0,  2'd1, 0, 1);
        step(0, 0, 13'h0,  13'h0,  2'd0, 0, 1);

        // Fill to DEPTH with four pairs; fifth pair dropped
        for (int i = 0; i < 4; i++) begin
            step(1, 1, PCW'(13'h100 + 8 * i), PCW'(13'h104 + 8 * i), 2'd0, 0, 1);
        end
        step(1, 1, 13'h1F0, 13'h1F4, 2'd0, 0, 1);
        #3;
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_ready", 64'(push_ready), 64'd0);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 13'h0, 13'h0, 2'd2, 0, 1);
        end

        // Wrap: bring wptr to DEPTH-1 then push a pair across the boundary
        step(0, 0, 13'h0, 13'h0, 2'd0, 1, 1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1, 0, PCW'(13'h200 + 4 * i), 13'h0, 2'd0, 0, 1);
            step(0, 0, 13'h0, 13'h0, 2'd1, 0, 1);
        end
        step(1, 1, 13'h3F8, 13'h3FC, 2'd0, 0, 1);
        step(0, 0, 13'h0, 13'h0, 2'd0, 0, 1);

        // Reach count=5, then flush together with push and pop
        step(1, 1, 13'h400, 13'h404, 2'd0, 0, 1);
        step(1, 0, 13'h408, 13'h0,   2'd0, 0, 1);
        step(1, 1, 13'h40C, 13'h410, 2'd2, 1, 1);
        step(0, 0, 13'h0, 13'h0, 2'd0, 0, 1);

        // Over-pop with a single-instruction push
        step(1, 0, 13'h500, 13'h0, 2'd0, 0, 1);
        step(1, 0, 13'h504, 13'h0, 2'd2, 0, 1);
        step(0, 0, 13'h0, 13'h0, 2'd3, 0, 1);
        step(0, 0, 13'h0, 13'h0, 2'd3, 0, 1);

`ifdef ISSUE_QUEUE_BYPASS_EN
        // Push and pop a pair in the same cycle at empty
        push_valid = 1'b1; push_second = 1'b1; pop_cnt = 2'd2;
        push_pc1 = 13'h600; push_pc2 = 13'h604;
        #3;
        chk("byp_valid1", 64'(out_valid1), 64'd1);
        chk("byp_valid2", 64'(out_valid2), 64'd1);
        chk("byp_pc2", 64'(out_pc2), 64'h604);
        @(posedge CLK);
        #1;
        push_valid = 1'b0; pop_cnt = 2'd0;
        #3;
        chk("byp_count", 64'(count), 64'd0);
        @(posedge CLK);
        #1;
`endif

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), 1'($urandom),
                 PCW'($urandom), PCW'($urandom), 2'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
